nibble_serial_addsub: RTL and testbench

//   Sequential front-end for the 4-bit add/subtract datapath. Accepts

---
 rtl/nibble_serial_addsub.sv | 70 +++++++
 tb/tb_nibble_serial_addsub.sv | 100 ++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: add/subtract NIBBLES*4-bit operands one nibble per clock, LSB first
module nibble_serial_addsub #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES,
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         d,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] S,
  output logic         Cout,
  output logic         ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_q, b_q, work, work_n;
  logic [IW-1:0] idx;
  logic d_q, carry, last, c3;
  logic [3:0] nb;
  logic [4:0] sum;
  always_comb begin
    nb = b_q[3:0] ^ {4{d_q}};
    sum = {1'b0, a_q[3:0]} + {1'b0, nb} + {4'b0, carry};
    c3 = a_q[3] ^ nb[3] ^ sum[3];
    work_n = (work >> 4) | (W'(sum[3:0]) << (W - 4));
    last = (idx == IW'(NIBBLES - 1));
    state_n = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  assign busy = (state == RUN);
  assign done = (state == DONE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // operands shift right so the active nibble is always in bits [3:0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      d_q <= 1'b0;
      carry <= 1'b0;
      idx <= '0;
      work <= '0;
      S <= '0;
      Cout <= 1'b0;
      ovf <= 1'b0;
    end else if (state != RUN && start) begin
      a_q <= A;
      b_q <= B;
      d_q <= d;
      carry <= d;
      idx <= '0;
    end else if (state == RUN) begin
      a_q <= a_q >> 4;
      b_q <= b_q >> 4;
      work <= work_n;
      carry <= sum[4];
      idx <= last ? '0 : idx + 1'b1;
      if (last) begin
        S <= work_n;
        Cout <= sum[4];
        ovf <= c3 ^ sum[4];
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// tb_nibble_serial_addsub: directed vectors for the serial add/subtract unit (NIBBLES=4)
module tb_nibble_serial_addsub;
  logic clk = 0, rst_n = 0, start = 0, d = 0;
  logic [15:0] A = 0, B = 0, S, prev_s;
  logic busy, done, Cout, ovf;
  int n_cmp = 0, n_bad = 0;

  nibble_serial_addsub #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .d(d),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // called #1 after an edge; start is sampled at the next edge
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic dd, input logic [15:0] es, input logic ec,
                        input logic eo, input bit glitch);
    int cyc, bcnt;
    start = 1; A = a; B = b; d = dd;
    @(posedge clk); #1;
    start = 0; A = 16'($urandom); B = 16'($urandom); d = 1'($urandom);
    check({tag, "_busy_e0"}, busy, 1);
    check({tag, "_hold_s"}, S, prev_s);
    bcnt = 1; cyc = 0;
    while (!done && cyc < 20) begin
      if (glitch && cyc < 2) begin start = 1; A = 16'hAAAA; B = 16'h5555; d = 1; end
      else start = 0;
      @(posedge clk); #1;
      cyc++;
      if (busy) bcnt++;
    end
    start = 0;
    check({tag, "_latency"}, cyc, 4);
    check({tag, "_busy_cycles"}, bcnt, 4);
    check({tag, "_done"}, done, 1);
    check({tag, "_S"}, S, es);
    check({tag, "_Cout"}, Cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    prev_s = es;
  endtask

  task automatic no_done(input string tag, input int n);
    int hits = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done) hits++;
    end
    check({tag, "_no_done"}, hits, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    prev_s = 0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_S", S, 0);
    check("rst_Cout", Cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    run_op("add", 16'h1234, 16'h0F0F, 0, 16'h2143, 0, 0, 0);
    no_done("add", 1);
    run_op("sub_ovf", 16'h8000, 16'h0003, 1, 16'h7FFD, 1, 1, 0);
    no_done("sub_ovf", 1);
    run_op("wrap", 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 0);
    no_done("wrap", 1);
    run_op("sub_neg", 16'h0003, 16'h0008, 1, 16'hFFFB, 0, 0, 0);
    run_op("b2b", 16'h0001, 16'h0001, 0, 16'h0002, 0, 0, 0);
    no_done("b2b", 1);
    run_op("ignore", 16'h4321, 16'h1111, 0, 16'h5432, 0, 0, 1);
    no_done("ignore", 8);
    start = 1; A = 16'h1111; B = 16'h2222; d = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_S", S, 0);
    check("arst_Cout", Cout, 0);
    @(negedge clk) rst_n = 1;
    prev_s = 0;
    no_done("arst", 8);
    run_op("post_rst", 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0);
    no_done("post_rst", 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
